// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage resynchronisation; both stages reset to the line's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: start/data/parity/stop recovery with
// one-cycle valid strobe and held parity/framing error flags.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 27,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 rx_busy,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  uart_state_t          r_state;
  uart_state_t          w_state_nx;
  logic                 w_rx_s;
  logic [DW-1:0]        r_div;
  logic [3:0]           r_smp;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_par_ok;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 w_tick;
  logic                 w_mid;
  logic                 w_centre;
  logic                 w_last_bit;

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );

  assign w_tick     = (r_state != IDLE) && (r_div == DW'(CLK_DIV - 1));
  assign w_mid      = w_tick && (r_smp == 4'(MID_SAMPLE));
  assign w_centre   = w_tick && (r_smp == 4'(OVERSAMPLE - 1));
  assign w_last_bit = (r_bit == 3'(DATA_BITS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic: start qualification at mid start bit, then one
  // sample per bit centre; a low stop bit parks in BREAK until the line rises.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:   if (!w_rx_s) w_state_nx = START;
      START:  if (w_mid) w_state_nx = w_rx_s ? IDLE : DATA;
      DATA:   if (w_centre && w_last_bit) w_state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (w_centre) w_state_nx = STOP;
      STOP:   if (w_centre) w_state_nx = w_rx_s ? IDLE : BREAK;
      BREAK:  if (w_rx_s) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Oversample divider and sample counter; both parked at zero in IDLE so
  // counting is aligned to the detected start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_smp <= '0;
    end else begin
      if (r_state == IDLE || w_tick) r_div <= '0;
      else                           r_div <= r_div + 1'b1;

      if (r_state == IDLE || (r_state == START && w_mid)) r_smp <= '0;
      else if (w_tick)                                    r_smp <= r_smp + 1'b1;
    end
  end

  // Datapath: shift data LSB first, accumulate parity, and publish the
  // frame together with its error flags on the stop-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_par_ok <= 1'b1;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        START: begin
          if (w_mid) begin
            r_bit <= '0;
            r_par <= 1'b0;
          end
        end
        DATA: begin
          if (w_centre) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_par   <= r_par ^ w_rx_s;
            r_bit   <= r_bit + 1'b1;
          end
        end
        PARITY: begin
          if (w_centre) r_par_ok <= ~(r_par ^ w_rx_s ^ 1'(PARITY_ODD));
        end
        STOP: begin
          if (w_centre) begin
            r_data  <= r_shift;
            r_perr  <= (PARITY_EN != 0) & ~r_par_ok;
            r_ferr  <= ~w_rx_s;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out   = r_data;
  assign valid      = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign rx_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at CLK_DIV=4 (64 clk per bit), 8E1.
module tb_uart_rx_os;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       rx_busy;
  logic       parity_err;
  logic       frame_err;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   vcount = 0;
  int   last_vcyc = 0;
  int   t_start = 0;
  logic prev_valid = 1'b0;

  uart_rx_os #(
    .CLK_DIV   (4),
    .DATA_BITS (8),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .rx_busy   (rx_busy),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: every valid pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      exp_t e;
      vcount++;
      last_vcyc = cyc;
      chk("valid_pulse_width", 32'(prev_valid), 0);
      chk("valid_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data_out", 32'(data_out), 32'(e.d));
        chk("parity_err", 32'(parity_err), 32'(e.pe));
        chk("frame_err", 32'(frame_err), 32'(e.fe));
      end
    end
    prev_valid = valid;
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (BIT_CLK - 1) @(negedge clk);
  endtask

  // One 8E1 frame; parity bit optionally corrupted, stop level selectable.
  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_v);
    exp_t e;
    e.d  = d;
    e.pe = par_bad;
    e.fe = ~stop_v;
    sb.push_back(e);
    @(negedge clk);
    t_start = cyc;
    rx = 1'b0;
    repeat (BIT_CLK - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((^d) ^ par_bad);
    drive_bit(stop_v);
  endtask

  initial begin
    int v0;
    int lat;
    logic [7:0] part;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(rx_busy), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(rx_busy), 0);

    // 1: clean frame, busy across the frame, latency
    fork
      send_frame(8'h20, 1'b0, 1'b1);
      begin
        repeat (300) @(negedge clk);
        chk("t1_busy_mid", 32'(rx_busy), 1);
      end
    join
    chk("t1_busy_after", 32'(rx_busy), 0);
    chk("t1_hold_data", 32'(data_out), 32'h20);
    lat = last_vcyc - t_start;
    chk("t1_latency", 32'(lat >= 672 && lat <= 680), 1);

    // 2: back-to-back frames with no idle bits
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (20) @(negedge clk);

    // 3: glitch shorter than half a bit is a false start
    v0 = vcount;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3_busy_glitch", 32'(rx_busy), 1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("t3_busy_after", 32'(rx_busy), 0);
    chk("t3_no_valid", 32'(vcount - v0), 0);

    // 4: bad parity, then a good frame clears the flag
    send_frame(8'h20, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("t4_perr_held", 32'(parity_err), 1);
    send_frame(8'h20, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("t4_perr_cleared", 32'(parity_err), 0);

    // 5: low stop bit followed by a held-low break
    v0 = vcount;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (1000) @(negedge clk);
    chk("t5_busy_break", 32'(rx_busy), 1);
    chk("t5_one_valid", 32'(vcount - v0), 1);
    chk("t5_ferr_held", 32'(frame_err), 1);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("t5_busy_release", 32'(rx_busy), 0);
    chk("t5_no_more_valid", 32'(vcount - v0), 1);

    // 6: reset during data bit 4 aborts the frame
    v0 = vcount;
    part = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(part[i]);
    @(negedge clk);
    rx = part[4];
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data_out", 32'(data_out), 0);
    chk("t6_rst_valid", 32'(valid), 0);
    chk("t6_rst_busy", 32'(rx_busy), 0);
    chk("t6_rst_perr", 32'(parity_err), 0);
    chk("t6_rst_ferr", 32'(frame_err), 0);
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("t6_no_valid", 32'(vcount - v0), 0);
    send_frame(8'h7E, 1'b0, 1'b1);
    repeat (200) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 0);
    chk("total_valids", 32'(vcount), 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
